anu_decode_exec: RTL and testbench

- Single-cycle decode/execute slice of the AnuRV32 RV32I core.
- Decodes one instruction, drives register-file read addresses, and selects ALU operands.
- Computes the ALU result, branch decision, next PC, load extension and store access mode.
- Registers the write-back triple (data, rd, wen) for the register file.
- Sits between instruction fetch/PC and the register file/data memory.

---
 rtl/anu_pkg.sv | 48 ++++
 rtl/anu_decode_exec_if.sv | 33 +++
 rtl/anu_alu.sv | 39 +++
 rtl/anu_load_ext.sv | 19 +
 rtl/anu_decode_exec.sv | 175 +++++++++++++++++
 tb/tb_anu_decode_exec.sv | 183 ++++++++++++++++++
 6 files changed

// File: rtl/anu_pkg.sv
// Shared definitions for the AnuRV32 decode/execute slice: opcodes,
// ctrl bit positions, ALU micro-ops and store access modes.
package anu_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam int CTRL_W       = 16;
    localparam int CTRL_OP      = 0;
    localparam int CTRL_I_FRAME = 1;
    localparam int CTRL_SHIFT   = 2;
    localparam int CTRL_LOAD    = 3;
    localparam int CTRL_STORE   = 4;
    localparam int CTRL_BRANCH  = 5;
    localparam int CTRL_JALR    = 6;
    localparam int CTRL_JAL     = 7;
    localparam int CTRL_AUIPC   = 8;
    localparam int CTRL_LUI     = 9;

    // Encodings line up with RV32I funct3 so decode can cast funct3 directly.
    typedef enum logic [2:0] {
        UOP_ADD  = 3'b000,
        UOP_SLL  = 3'b001,
        UOP_SLT  = 3'b010,
        UOP_SLTU = 3'b011,
        UOP_XOR  = 3'b100,
        UOP_SR   = 3'b101,
        UOP_OR   = 3'b110,
        UOP_AND  = 3'b111
    } alu_uop_e;

    typedef enum logic [1:0] {
        MEM_NONE = 2'b00,
        MEM_BYTE = 2'b01,
        MEM_HALF = 2'b10,
        MEM_WORD = 2'b11
    } mem_mode_e;

endpackage

// File: rtl/anu_decode_exec_if.sv
// Bundle between fetch/register file/data memory and the decode/execute slice.
interface anu_decode_exec_if;
    logic        stall;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] data_in;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [15:0] ctrl;
    logic [31:0] alu_out;
    logic        zero;
    logic [1:0]  mem_mode;
    logic [31:0] data_out;
    logic [31:0] next_pc;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_wen;

    modport master (
        output stall, instr, pc, rs1_data, rs2_data, data_in,
        input  rs1, rs2, imm, ctrl, alu_out, zero, mem_mode, data_out,
               next_pc, wb_data, wb_rd, wb_wen
    );

    modport slave (
        input  stall, instr, pc, rs1_data, rs2_data, data_in,
        output rs1, rs2, imm, ctrl, alu_out, zero, mem_mode, data_out,
               next_pc, wb_data, wb_rd, wb_wen
    );
endinterface

// File: rtl/anu_alu.sv
// RV32I integer ALU; f7 turns add into sub and a logical right shift into arithmetic.
module anu_alu
    import anu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  alu_uop_e        uop,
    input  logic            f7,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    logic [4:0] shamt;
    assign shamt = op2[4:0];

    // Shifts stay in separate if branches so >>> keeps its signed context.
    always_comb begin
        result = '0;
        case (uop)
            UOP_ADD:  result = f7 ? (op1 - op2) : (op1 + op2);
            UOP_SLL:  result = op1 << shamt;
            UOP_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
            UOP_SLTU: result = {{(XLEN-1){1'b0}}, (op1 < op2)};
            UOP_XOR:  result = op1 ^ op2;
            UOP_SR: begin
                if (f7) result = $signed(op1) >>> shamt;
                else    result = op1 >> shamt;
            end
            UOP_OR:   result = op1 | op2;
            UOP_AND:  result = op1 & op2;
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/anu_load_ext.sv
// Load extender: picks byte/half/word from memory data and sign- or zero-extends it.
module anu_load_ext (
    input  logic [2:0]  funct3,
    input  logic [31:0] data_in,
    output logic [31:0] data_ext
);

    logic sign;
    assign sign = ~funct3[2];

    always_comb begin
        data_ext = data_in;
        if (!funct3[1]) begin
            if (!funct3[0]) data_ext = {{24{sign & data_in[7]}}, data_in[7:0]};
            else            data_ext = {{16{sign & data_in[15]}}, data_in[15:0]};
        end
    end

endmodule

// File: rtl/anu_decode_exec.sv
// Single-cycle RV32I decode/execute slice with a registered write-back triple.
module anu_decode_exec
    import anu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic               clk,
    input logic               rst,
    anu_decode_exec_if.slave  bus
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [XLEN-1:0] instr;

    assign instr  = bus.instr;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign rd     = instr[11:7];

    logic is_op, is_op_imm, is_load, is_store, is_branch;
    logic is_jalr, is_jal, is_auipc, is_lui;
    logic i_frame, shift, valid;

    assign is_op     = (opcode == OPC_OP);
    assign is_op_imm = (opcode == OPC_OP_IMM);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_jalr   = (opcode == OPC_JALR);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_auipc  = (opcode == OPC_AUIPC);
    assign is_lui    = (opcode == OPC_LUI);

    assign i_frame = is_op_imm | is_load | is_jalr;
    assign shift   = (is_op | is_op_imm) & (funct3[1:0] == 2'b01);
    assign valid   = is_op | is_op_imm | is_load | is_store | is_branch |
                     is_jalr | is_jal | is_auipc | is_lui;

    always_comb begin
        bus.ctrl                = '0;
        bus.ctrl[CTRL_OP]       = is_op;
        bus.ctrl[CTRL_I_FRAME]  = i_frame;
        bus.ctrl[CTRL_SHIFT]    = shift;
        bus.ctrl[CTRL_LOAD]     = is_load;
        bus.ctrl[CTRL_STORE]    = is_store;
        bus.ctrl[CTRL_BRANCH]   = is_branch;
        bus.ctrl[CTRL_JALR]     = is_jalr;
        bus.ctrl[CTRL_JAL]      = is_jal;
        bus.ctrl[CTRL_AUIPC]    = is_auipc;
        bus.ctrl[CTRL_LUI]      = is_lui;
    end

    logic [XLEN-1:0] imm;

    always_comb begin
        imm = '0;
        if (i_frame)
            imm = {{20{instr[31]}}, instr[31:20]};
        else if (is_store)
            imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        else if (is_branch)
            imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        else if (is_lui | is_auipc)
            imm = {instr[31:12], 12'b0};
        else if (is_jal)
            imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    end

    assign bus.imm      = imm;
    assign bus.rs1      = instr[19:15];
    assign bus.rs2      = instr[24:20];
    assign bus.data_out = bus.rs2_data;

    logic [XLEN-1:0] op1, op2, alu_out;
    logic            zero;
    alu_uop_e        uop;
    logic            f7;

    assign op1 = is_auipc ? bus.pc : bus.rs1_data;
    assign op2 = (i_frame | is_store | is_auipc) ? imm : bus.rs2_data;

    // Branches reuse the ALU as a comparator: sub for eq/ne, slt/sltu for ordering.
    always_comb begin
        uop = alu_uop_e'(funct3);
        f7  = instr[30] & (shift | ~i_frame);
        if (is_load | is_store | is_auipc | is_jalr) begin
            uop = UOP_ADD;
            f7  = 1'b0;
        end else if (is_branch) begin
            case (funct3[2:1])
                2'b00: begin uop = UOP_ADD;  f7 = 1'b1; end
                2'b10: begin uop = UOP_SLT;  f7 = 1'b0; end
                2'b11: begin uop = UOP_SLTU; f7 = 1'b0; end
                default: ;
            endcase
        end
    end

    anu_alu #(.XLEN(XLEN)) u_alu (
        .op1    (op1),
        .op2    (op2),
        .uop    (uop),
        .f7     (f7),
        .result (alu_out),
        .zero   (zero)
    );

    assign bus.alu_out = alu_out;
    assign bus.zero    = zero;

    logic            taken;
    logic [XLEN-1:0] pc_plus4, pc_plus_imm;

    assign taken       = is_branch & ((funct3[2] ^ funct3[0]) ? ~zero : zero);
    assign pc_plus4    = bus.pc + 32'd4;
    assign pc_plus_imm = bus.pc + imm;

    always_comb begin
        if (bus.stall)           bus.next_pc = bus.pc;
        else if (is_jalr)        bus.next_pc = alu_out & ~32'd1;
        else if (is_jal | taken) bus.next_pc = pc_plus_imm;
        else                     bus.next_pc = pc_plus4;
    end

    mem_mode_e mem_mode;

    always_comb begin
        mem_mode = MEM_NONE;
        if (is_store) begin
            case (funct3[1:0])
                2'b00:   mem_mode = MEM_BYTE;
                2'b01:   mem_mode = MEM_HALF;
                2'b10:   mem_mode = MEM_WORD;
                default: mem_mode = MEM_NONE;
            endcase
        end
    end

    assign bus.mem_mode = mem_mode;

    logic [XLEN-1:0] load_data;

    anu_load_ext u_load_ext (
        .funct3   (funct3),
        .data_in  (bus.data_in),
        .data_ext (load_data)
    );

    logic [XLEN-1:0] wb_data_next;
    logic            wb_wen_next;

    always_comb begin
        if (is_load)               wb_data_next = load_data;
        else if (is_lui)           wb_data_next = imm;
        else if (is_jal | is_jalr) wb_data_next = pc_plus4;
        else                       wb_data_next = alu_out;
    end

    assign wb_wen_next = valid & ~is_store & ~is_branch & (rd != 5'd0) & ~bus.stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.wb_data <= '0;
            bus.wb_rd   <= '0;
            bus.wb_wen  <= 1'b0;
        end else begin
            bus.wb_data <= wb_data_next;
            bus.wb_rd   <= rd;
            bus.wb_wen  <= wb_wen_next;
        end
    end

endmodule

// File: tb/tb_anu_decode_exec.sv
// Directed bench for anu_decode_exec: a vector table for single instructions
// plus hand-written sequences for decode fields, stall and mid-cycle reset.
module tb_anu_decode_exec;
    import anu_pkg::*;

    logic clk;
    logic rst;

    anu_decode_exec_if bus ();

    anu_decode_exec dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_count = 0;
    int total_count = 0;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] data_in;
        logic        stall;
        logic [31:0] exp_alu;
        logic [31:0] exp_next_pc;
        logic [1:0]  exp_mode;
        logic [31:0] exp_wb_data;
        logic        exp_wen;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic [31:0] ins, logic [31:0] p,
                                logic [31:0] r1, logic [31:0] r2, logic [31:0] din,
                                logic st, logic [31:0] ealu, logic [31:0] enpc,
                                logic [1:0] emode, logic [31:0] ewbd, logic ewen);
        vec_t v;
        v.name = n; v.instr = ins; v.pc = p; v.rs1_data = r1; v.rs2_data = r2;
        v.data_in = din; v.stall = st; v.exp_alu = ealu; v.exp_next_pc = enpc;
        v.exp_mode = emode; v.exp_wb_data = ewbd; v.exp_wen = ewen;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total_count++;
        if (actual !== expected)
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
        else
            pass_count++;
    endtask

    task automatic driveInputs(input logic [31:0] ins, input logic [31:0] p,
                               input logic [31:0] r1, input logic [31:0] r2,
                               input logic [31:0] din, input logic st);
        bus.instr = ins; bus.pc = p; bus.rs1_data = r1; bus.rs2_data = r2;
        bus.data_in = din; bus.stall = st;
    endtask

    task automatic applyStimulus(input vec_t v);
        driveInputs(v.instr, v.pc, v.rs1_data, v.rs2_data, v.data_in, v.stall);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //          name       instr         pc       rs1_data      rs2_data      data_in       st  alu           next_pc       mode   wb_data       wen
        vecs.push_back(mk("addi",  32'h00500093, 32'h000, 32'h0,        32'h0,        32'h0,        0, 32'h5,        32'h004,      2'b00, 32'h5,        1));
        vecs.push_back(mk("sub",   32'h402081B3, 32'h040, 32'h5,        32'h7,        32'h0,        0, 32'hFFFFFFFE, 32'h044,      2'b00, 32'hFFFFFFFE, 1));
        vecs.push_back(mk("sra",   32'h4020D1B3, 32'h040, 32'h80000000, 32'h4,        32'h0,        0, 32'hF8000000, 32'h044,      2'b00, 32'hF8000000, 1));
        vecs.push_back(mk("srl",   32'h0020D1B3, 32'h040, 32'h80000000, 32'h4,        32'h0,        0, 32'h08000000, 32'h044,      2'b00, 32'h08000000, 1));
        vecs.push_back(mk("srai",  32'h4040D093, 32'h040, 32'h80000000, 32'h0,        32'h0,        0, 32'hF8000000, 32'h044,      2'b00, 32'hF8000000, 1));
        vecs.push_back(mk("addin", 32'hC0000093, 32'h040, 32'h0,        32'h0,        32'h0,        0, 32'hFFFFFC00, 32'h044,      2'b00, 32'hFFFFFC00, 1));
        vecs.push_back(mk("sll",   32'h002091B3, 32'h040, 32'h1,        32'h21,       32'h0,        0, 32'h2,        32'h044,      2'b00, 32'h2,        1));
        vecs.push_back(mk("slt",   32'h0020A1B3, 32'h040, 32'hFFFFFFFF, 32'h1,        32'h0,        0, 32'h1,        32'h044,      2'b00, 32'h1,        1));
        vecs.push_back(mk("sltu",  32'h0020B1B3, 32'h040, 32'hFFFFFFFF, 32'h1,        32'h0,        0, 32'h0,        32'h044,      2'b00, 32'h0,        1));
        vecs.push_back(mk("xor",   32'h0020C1B3, 32'h040, 32'hF0,       32'hFF,       32'h0,        0, 32'h0F,       32'h044,      2'b00, 32'h0F,       1));
        vecs.push_back(mk("or",    32'h0020E1B3, 32'h040, 32'hF0,       32'hFF,       32'h0,        0, 32'hFF,       32'h044,      2'b00, 32'hFF,       1));
        vecs.push_back(mk("and",   32'h0020F1B3, 32'h040, 32'hF0,       32'hFF,       32'h0,        0, 32'hF0,       32'h044,      2'b00, 32'hF0,       1));
        vecs.push_back(mk("beq_t", 32'h00208463, 32'h100, 32'h9,        32'h9,        32'h0,        0, 32'h0,        32'h108,      2'b00, 32'h0,        0));
        vecs.push_back(mk("beq_n", 32'h00208463, 32'h100, 32'h9,        32'h3,        32'h0,        0, 32'h6,        32'h104,      2'b00, 32'h6,        0));
        vecs.push_back(mk("bltu",  32'h0020E463, 32'h100, 32'h1,        32'hFFFFFFFF, 32'h0,        0, 32'h1,        32'h108,      2'b00, 32'h1,        0));
        vecs.push_back(mk("blt",   32'h0020C463, 32'h100, 32'hFFFFFFFF, 32'h1,        32'h0,        0, 32'h1,        32'h108,      2'b00, 32'h1,        0));
        vecs.push_back(mk("bge",   32'h0020D463, 32'h100, 32'hFFFFFFFF, 32'h1,        32'h0,        0, 32'h1,        32'h104,      2'b00, 32'h1,        0));
        vecs.push_back(mk("lb",    32'h00008283, 32'h020, 32'h1000,     32'h0,        32'h00000080, 0, 32'h1000,     32'h024,      2'b00, 32'hFFFFFF80, 1));
        vecs.push_back(mk("lbu",   32'h0000C283, 32'h020, 32'h1000,     32'h0,        32'h00000080, 0, 32'h1000,     32'h024,      2'b00, 32'h00000080, 1));
        vecs.push_back(mk("lh",    32'h00009283, 32'h020, 32'h1000,     32'h0,        32'h00008001, 0, 32'h1000,     32'h024,      2'b00, 32'hFFFF8001, 1));
        vecs.push_back(mk("lhu",   32'h0000D283, 32'h020, 32'h1000,     32'h0,        32'h00008001, 0, 32'h1000,     32'h024,      2'b00, 32'h00008001, 1));
        vecs.push_back(mk("lw",    32'h0000A283, 32'h020, 32'h1000,     32'h0,        32'hDEADBEEF, 0, 32'h1000,     32'h024,      2'b00, 32'hDEADBEEF, 1));
        vecs.push_back(mk("sw",    32'h0020A223, 32'h030, 32'h10,       32'hAB,       32'h0,        0, 32'h14,       32'h034,      2'b11, 32'h14,       0));
        vecs.push_back(mk("sh",    32'h00209223, 32'h030, 32'h10,       32'hAB,       32'h0,        0, 32'h14,       32'h034,      2'b10, 32'h14,       0));
        vecs.push_back(mk("sb",    32'h00208223, 32'h030, 32'h10,       32'hAB,       32'h0,        0, 32'h14,       32'h034,      2'b01, 32'h14,       0));
        vecs.push_back(mk("jal",   32'h010000EF, 32'h200, 32'h0,        32'h0,        32'h0,        0, 32'h0,        32'h210,      2'b00, 32'h204,      1));
        vecs.push_back(mk("jal_st",32'h010000EF, 32'h200, 32'h0,        32'h0,        32'h0,        1, 32'h0,        32'h200,      2'b00, 32'h204,      0));
        vecs.push_back(mk("jalr",  32'h005100E7, 32'h300, 32'h1000,     32'h0,        32'h0,        0, 32'h1005,     32'h1004,     2'b00, 32'h304,      1));
        vecs.push_back(mk("lui",   32'h123452B7, 32'h010, 32'h0,        32'h0,        32'h0,        0, 32'h0,        32'h014,      2'b00, 32'h12345000, 1));
        vecs.push_back(mk("auipc", 32'h00001197, 32'h400, 32'h0,        32'h0,        32'h0,        0, 32'h1400,     32'h404,      2'b00, 32'h1400,     1));
        vecs.push_back(mk("x0dst", 32'h00100013, 32'h000, 32'h0,        32'h0,        32'h0,        0, 32'h1,        32'h004,      2'b00, 32'h1,        0));
        vecs.push_back(mk("unk",   32'h0000007F, 32'h000, 32'h3,        32'h4,        32'h0,        0, 32'h7,        32'h004,      2'b00, 32'h7,        0));

        // Reset state: wb_* must stay 0 across a clock edge while rst is high.
        rst = 1'b1;
        driveInputs(32'h00500093, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        @(posedge clk); #1;
        checkOutput("reset_wb_data", bus.wb_data, 32'h0);
        checkOutput("reset_wb_rd",   {27'd0, bus.wb_rd}, 32'h0);
        checkOutput("reset_wb_wen",  {31'd0, bus.wb_wen}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #3;
            checkOutput({vecs[i].name, "_alu"},  bus.alu_out, vecs[i].exp_alu);
            checkOutput({vecs[i].name, "_npc"},  bus.next_pc, vecs[i].exp_next_pc);
            checkOutput({vecs[i].name, "_mode"}, {30'd0, bus.mem_mode}, {30'd0, vecs[i].exp_mode});
            @(posedge clk); #1;
            if (!vecs[i].stall)
                checkOutput({vecs[i].name, "_wbd"}, bus.wb_data, vecs[i].exp_wb_data);
            checkOutput({vecs[i].name, "_wen"}, {31'd0, bus.wb_wen}, {31'd0, vecs[i].exp_wen});
            checkOutput({vecs[i].name, "_wbrd"}, {27'd0, bus.wb_rd}, {27'd0, vecs[i].instr[11:7]});
        end

        // Decode fields not covered by the table.
        driveInputs(32'h00500093, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0); #3;
        checkOutput("addi_imm",  bus.imm, 32'h5);
        checkOutput("addi_ctrl", {16'd0, bus.ctrl}, 32'h0002);
        driveInputs(32'h402081B3, 32'h0, 32'h5, 32'h7, 32'h0, 1'b0); #3;
        checkOutput("sub_zero", {31'd0, bus.zero}, 32'h0);
        checkOutput("sub_rs1",  {27'd0, bus.rs1}, 32'h1);
        checkOutput("sub_rs2",  {27'd0, bus.rs2}, 32'h2);
        checkOutput("sub_ctrl", {16'd0, bus.ctrl}, 32'h0001);
        driveInputs(32'h4020D1B3, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0); #3;
        checkOutput("sra_ctrl", {16'd0, bus.ctrl}, 32'h0005);
        driveInputs(32'h00208463, 32'h100, 32'h9, 32'h9, 32'h0, 1'b0); #3;
        checkOutput("beq_zero", {31'd0, bus.zero}, 32'h1);
        checkOutput("beq_imm",  bus.imm, 32'h8);
        driveInputs(32'h0020A223, 32'h30, 32'h10, 32'hAB, 32'h0, 1'b0); #3;
        checkOutput("sw_imm",  bus.imm, 32'h4);
        checkOutput("sw_ctrl", {16'd0, bus.ctrl}, 32'h0010);
        checkOutput("sw_data_out", bus.data_out, 32'hAB);
        driveInputs(32'h00008283, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0); #3;
        checkOutput("lb_ctrl", {16'd0, bus.ctrl}, 32'h000A);
        driveInputs(32'h005100E7, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0); #3;
        checkOutput("jalr_ctrl", {16'd0, bus.ctrl}, 32'h0042);
        driveInputs(32'h0000007F, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0); #3;
        checkOutput("unk_ctrl", {16'd0, bus.ctrl}, 32'h0);
        checkOutput("unk_imm",  bus.imm, 32'h0);
        driveInputs(32'h010000EF, 32'h200, 32'h0, 32'h0, 32'h0, 1'b0); #3;
        checkOutput("jal_imm",  bus.imm, 32'h10);
        checkOutput("jal_ctrl", {16'd0, bus.ctrl}, 32'h0080);

        // Mid-cycle reset clears write-back without waiting for a clock edge.
        @(posedge clk); #1;
        checkOutput("pre_rst_wen",  {31'd0, bus.wb_wen}, 32'h1);
        checkOutput("pre_rst_data", bus.wb_data, 32'h204);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_wb_data", bus.wb_data, 32'h0);
        checkOutput("midrst_wb_rd",   {27'd0, bus.wb_rd}, 32'h0);
        checkOutput("midrst_wb_wen",  {31'd0, bus.wb_wen}, 32'h0);
        @(posedge clk); #1;
        checkOutput("held_rst_wen", {31'd0, bus.wb_wen}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("post_rst_wen",  {31'd0, bus.wb_wen}, 32'h1);
        checkOutput("post_rst_data", bus.wb_data, 32'h204);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
